vga_scan_timing: RTL and testbench

- Generates the VGA raster scan for the robotic-arm display path at 640x480@60 Hz from the 50 MHz board clock.
- Produces the `counterX`/`counterY` scan position consumed by the coordinate text renderer.
- Produces the hsync/vsync/video_on outputs for the DAC/connector.
- Holds frame-stable, 999-clamped snapshots of the arm X/Y/Z coordinates so the rendered digits never tear mid-frame.

---
 rtl/vga_scan_timing.sv | 133 +++++++++++++
 tb/tb_vga_scan_timing.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_timing.sv
// VGA raster scan generator: pixel-rate divider, X/Y scan counters, registered sync/blank,
// and coordinate snapshots latched at the start of vertical blank so rendered digits stay stable.
module vga_scan_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter int SYNC_POL  = 0,
  parameter int COORD_MAX = 999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [9:0] z_in,
  output logic       pix_tick,
  output logic [9:0] counterX,
  output logic [9:0] counterY,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic [9:0] x_snap,
  output logic [9:0] y_snap,
  output logic [9:0] z_snap
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_FIRST  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] C_MAX     = 10'(COORD_MAX);
  localparam logic       SP        = 1'(SYNC_POL);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [9:0]       cx_q, cx_d, cy_q, cy_d;
  logic             hs_q, hs_d, vs_q, vs_d, vid_q, vid_d, fs_q, fs_d;
  logic [9:0]       xs_q, xs_d, ys_q, ys_d, zs_q, zs_d;
  logic             snap_now;

  function automatic logic [9:0] clamp(input logic [9:0] v);
    return (v > C_MAX) ? C_MAX : v;
  endfunction

  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d = (div_d == DIV_LAST);

    cx_d = cx_q;
    cy_d = cy_q;
    if (tick_q) begin
      if (cx_q == H_LAST) begin
        cx_d = '0;
        cy_d = (cy_q == V_LAST) ? 10'd0 : cy_q + 10'd1;
      end else begin
        cx_d = cx_q + 10'd1;
      end
    end

    // Sync/blank follow the counters' next value so they line up with counterX/counterY.
    hs_d  = hs_q;
    vs_d  = vs_q;
    vid_d = vid_q;
    if (tick_q) begin
      hs_d  = ((cx_d >= HS_FIRST) && (cx_d <= HS_LAST)) ? SP : ~SP;
      vs_d  = ((cy_d >= VS_FIRST) && (cy_d <= VS_LAST)) ? SP : ~SP;
      vid_d = (cx_d < H_VIS) && (cy_d < V_VIS);
    end

    fs_d = tick_d && (cx_d == H_LAST) && (cy_d == V_LAST);

    snap_now = tick_q && (cx_q == H_LAST) && (cy_q == V_VIS_END);
    xs_d = snap_now ? clamp(x_in) : xs_q;
    ys_d = snap_now ? clamp(y_in) : ys_q;
    zs_d = snap_now ? clamp(z_in) : zs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      cx_q   <= '0;
      cy_q   <= '0;
      hs_q   <= ~SP;
      vs_q   <= ~SP;
      vid_q  <= 1'b0;
      fs_q   <= 1'b0;
      xs_q   <= '0;
      ys_q   <= '0;
      zs_q   <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      vid_q  <= vid_d;
      fs_q   <= fs_d;
      xs_q   <= xs_d;
      ys_q   <= ys_d;
      zs_q   <= zs_d;
    end
  end

  assign pix_tick    = tick_q;
  assign counterX    = cx_q;
  assign counterY    = cy_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = vid_q;
  assign frame_start = fs_q;
  assign x_snap      = xs_q;
  assign y_snap      = ys_q;
  assign z_snap      = zs_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench: one default-size instance for line timing, plus two shrunken rasters
// (CLK_DIV=2 active-low, CLK_DIV=1 active-high) so whole frames fit in a short run.
module tb_vga_scan_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] x_in = '0, y_in = '0, z_in = '0;
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  logic d_tick, d_hs, d_vs, d_vid, d_fs;
  logic [9:0] d_cx, d_cy, d_xs, d_ys, d_zs;
  logic s_tick, s_hs, s_vs, s_vid, s_fs;
  logic [9:0] s_cx, s_cy, s_xs, s_ys, s_zs;
  logic o_tick, o_hs, o_vs, o_vid, o_fs;
  logic [9:0] o_cx, o_cy, o_xs, o_ys, o_zs;

  vga_scan_timing dut_def (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .pix_tick(d_tick), .counterX(d_cx), .counterY(d_cy), .hsync(d_hs), .vsync(d_vs),
    .video_on(d_vid), .frame_start(d_fs), .x_snap(d_xs), .y_snap(d_ys), .z_snap(d_zs));

  // 15 x 11 raster: hsync on x 10..12, vsync on lines 7..8, visible 8 x 6
  vga_scan_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(2), .SYNC_POL(0), .COORD_MAX(999)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .pix_tick(s_tick), .counterX(s_cx), .counterY(s_cy), .hsync(s_hs), .vsync(s_vs),
    .video_on(s_vid), .frame_start(s_fs), .x_snap(s_xs), .y_snap(s_ys), .z_snap(s_zs));

  vga_scan_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(1), .SYNC_POL(1), .COORD_MAX(999)
  ) dut_o (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .pix_tick(o_tick), .counterX(o_cx), .counterY(o_cy), .hsync(o_hs), .vsync(o_vs),
    .video_on(o_vid), .frame_start(o_fs), .x_snap(o_xs), .y_snap(o_ys), .z_snap(o_zs));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic release_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    x_in = 10'd300; y_in = 10'd400; z_in = 10'd500;
    repeat (3) @(negedge clk);
    checks++;
    if ({d_tick, d_fs, d_vid, d_hs, d_vs, d_cx, d_cy, d_xs, d_ys, d_zs} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL reset_def got tick=%b fs=%b vid=%b hs=%b vs=%b x=%0d y=%0d snaps=%0d/%0d/%0d want 0 0 0 1 1 0 0 0/0/0",
               d_tick, d_fs, d_vid, d_hs, d_vs, d_cx, d_cy, d_xs, d_ys, d_zs);
    end
    checks++;
    if ({s_tick, s_fs, s_vid, s_hs, s_vs, s_cx, s_cy, s_xs, s_ys, s_zs} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL reset_small got tick=%b hs=%b vs=%b x=%0d y=%0d want tick=0 hs=1 vs=1 x=0 y=0",
               s_tick, s_hs, s_vs, s_cx, s_cy);
    end
    checks++;
    if ({o_tick, o_fs, o_vid, o_hs, o_vs, o_cx, o_cy, o_xs, o_ys, o_zs} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL reset_pol1 got tick=%b hs=%b vs=%b x=%0d y=%0d want tick=0 hs=0 vs=0 x=0 y=0",
               o_tick, o_hs, o_vs, o_cx, o_cy);
    end
  endtask

  // Default geometry: first 1600 clks cover exactly one 800-pixel line.
  task automatic test_line_default();
    int hs_low = 0;
    logic [9:0] ex, ey;
    logic et, eh, ev;
    x_in = '0; y_in = '0; z_in = '0;
    release_reset();
    for (int k = 1; k <= 1600; k++) begin
      tick();
      et = (k % 2) == 1;
      ex = 10'((k / 2) % 800);
      ey = 10'((k / 2) / 800);
      eh = !((ex >= 10'd656) && (ex <= 10'd751));
      ev = (k >= 2) && (ex < 10'd640) && (ey < 10'd480);
      checks++;
      if ({d_tick, d_cx, d_cy, d_hs, d_vs, d_vid, d_fs} !== {et, ex, ey, eh, 1'b1, ev, 1'b0}) begin
        errors++;
        $display("FAIL line_def cyc=%0d got tick=%b x=%0d y=%0d hs=%b vs=%b vid=%b fs=%b want %b %0d %0d %b 1 %b 0",
                 k, d_tick, d_cx, d_cy, d_hs, d_vs, d_vid, d_fs, et, ex, ey, eh, ev);
      end
      if (d_tick && !d_hs) hs_low++;
    end
    checks++;
    if (hs_low != 96) begin
      errors++;
      $display("FAIL hsync_width got %0d pixels want 96", hs_low);
    end
  endtask

  // Two-plus frames on the shrunken rasters, checked every clk against a pixel-index model.
  task automatic test_frames();
    int vid_cnt = 0;
    int p, p1;
    logic [9:0] ex, ey, ox, oy;
    logic et, eh, ev, evid, efs, oh, ov, ovid, ofs;
    release_reset();
    for (int k = 1; k <= 680; k++) begin
      tick();
      p    = k / 2;
      et   = (k % 2) == 1;
      ex   = 10'(p % 15);
      ey   = 10'((p / 15) % 11);
      eh   = !((ex >= 10'd10) && (ex <= 10'd12));
      ev   = !((ey >= 10'd7) && (ey <= 10'd8));
      evid = (k >= 2) && (ex < 10'd8) && (ey < 10'd6);
      efs  = et && ((p % 165) == 164);
      checks++;
      if ({s_tick, s_cx, s_cy, s_hs, s_vs, s_vid, s_fs} !== {et, ex, ey, eh, ev, evid, efs}) begin
        errors++;
        $display("FAIL frame_small cyc=%0d got tick=%b x=%0d y=%0d hs=%b vs=%b vid=%b fs=%b want %b %0d %0d %b %b %b %b",
                 k, s_tick, s_cx, s_cy, s_hs, s_vs, s_vid, s_fs, et, ex, ey, eh, ev, evid, efs);
      end
      p1   = k - 1;
      ox   = 10'(p1 % 15);
      oy   = 10'((p1 / 15) % 11);
      oh   = (ox >= 10'd10) && (ox <= 10'd12);
      ov   = (oy >= 10'd7) && (oy <= 10'd8);
      ovid = (k >= 2) && (ox < 10'd8) && (oy < 10'd6);
      ofs  = (p1 % 165) == 164;
      checks++;
      if ({o_tick, o_cx, o_cy, o_hs, o_vs, o_vid, o_fs} !== {1'b1, ox, oy, oh, ov, ovid, ofs}) begin
        errors++;
        $display("FAIL frame_div1 cyc=%0d got tick=%b x=%0d y=%0d hs=%b vs=%b vid=%b fs=%b want 1 %0d %0d %b %b %b %b",
                 k, o_tick, o_cx, o_cy, o_hs, o_vs, o_vid, o_fs, ox, oy, oh, ov, ovid, ofs);
      end
      if (k >= 331 && k <= 659 && s_tick && s_vid) vid_cnt++;
    end
    checks++;
    if (vid_cnt != 48) begin
      errors++;
      $display("FAIL visible_pixels got %0d want 48", vid_cnt);
    end
  endtask

  // Vblank starts (0,6) after edges 180, 510, 840; inputs are sampled in the clk before.
  task automatic test_snapshot();
    logic [29:0] exp;
    x_in = 10'd100; y_in = 10'd5; z_in = 10'd1000;
    release_reset();
    for (int k = 1; k <= 850; k++) begin
      tick();
      if (k < 180)       exp = {10'd0, 10'd0, 10'd0};
      else if (k < 510)  exp = {10'd512, 10'd5, 10'd999};
      else if (k < 840)  exp = {10'd37, 10'd5, 10'd999};
      else               exp = {10'd999, 10'd999, 10'd0};
      checks++;
      if ({s_xs, s_ys, s_zs} !== exp) begin
        errors++;
        $display("FAIL snapshot cyc=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, s_xs, s_ys, s_zs, exp[29:20], exp[19:10], exp[9:0]);
      end
      if (k == 180) begin
        checks++;
        if ({s_cx, s_cy} !== {10'd0, 10'd6}) begin
          errors++;
          $display("FAIL snap_position got x=%0d y=%0d want 0 6", s_cx, s_cy);
        end
      end
      if (k == 179) x_in = 10'd512;
      if (k == 390) x_in = 10'd37;
      if (k == 839) begin x_in = 10'd1023; y_in = 10'd999; z_in = 10'd0; end
      if (k == 840) begin x_in = 10'd5; y_in = 10'd6; z_in = 10'd7; end
    end
  endtask

  task automatic test_async_reset();
    x_in = 10'd200; y_in = 10'd200; z_in = 10'd200;
    release_reset();
    repeat (101) tick();
    checks++;
    if ({s_tick, s_cx, s_cy} !== {1'b1, 10'd5, 10'd3}) begin
      errors++;
      $display("FAIL pre_reset_pos got tick=%b x=%0d y=%0d want 1 5 3", s_tick, s_cx, s_cy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_tick, s_fs, s_vid, s_hs, s_vs, s_cx, s_cy} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL async_reset_small got tick=%b vid=%b hs=%b vs=%b x=%0d y=%0d want 0 0 1 1 0 0",
               s_tick, s_vid, s_hs, s_vs, s_cx, s_cy);
    end
    checks++;
    if ({o_tick, o_vid, o_hs, o_vs, o_cx, o_cy, o_xs} !== {1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL async_reset_div1 got tick=%b vid=%b hs=%b x=%0d y=%0d xs=%0d want 0 0 0 0 0 0",
               o_tick, o_vid, o_hs, o_cx, o_cy, o_xs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({s_tick, s_cx, s_cy} !== {1'b0, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL restart_c0 got tick=%b x=%0d y=%0d want 0 0 0", s_tick, s_cx, s_cy);
    end
    tick();
    checks++;
    if ({s_tick, s_cx, s_cy, s_vid} !== {1'b1, 10'd0, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL restart_c1 got tick=%b x=%0d y=%0d vid=%b want 1 0 0 0", s_tick, s_cx, s_cy, s_vid);
    end
    tick();
    checks++;
    if ({s_tick, s_cx, s_cy, s_vid} !== {1'b0, 10'd1, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart_c2 got tick=%b x=%0d y=%0d vid=%b want 0 1 0 1", s_tick, s_cx, s_cy, s_vid);
    end
  endtask

  initial begin
    test_reset();
    test_line_default();
    test_frames();
    test_snapshot();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
